// File: rtl/hs_fifo_pkg.sv
// rtl/hs_fifo_pkg.sv - shared sizing helpers and defaults for the programmable handshake FIFO
// Contents:
//   THRESH_OFFSET  default distance of the almost-full/almost-empty thresholds from full/empty
//   clog2()        ceiling log2 for parameter derivation
//   ptr_width()    pointer/level width: address bits plus one wrap bit
package hs_fifo_pkg;

    localparam int THRESH_OFFSET = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs_fifo_ram.sv
// rtl/hs_fifo_ram.sv - DEPTH x WIDTH simple dual-port storage array, sync write / async read
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// The array has no reset; contents are qualified by the FIFO pointers.
module hs_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_prog.sv
// rtl/hs_fifo_prog.sv - first-word-fall-through handshake FIFO with flush, level, thresholds and sticky errors
// Build option: HS_FIFO_STATUS_EN enables level, almost_full/almost_empty and the sticky
//   overflow/underflow flags; without it those outputs are tied to 0 and err_clr is ignored.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous empty request, wins over push/pop
//   wr_en, wr_data, data_in_ready    producer side handshake
//   rd_en, rd_data, data_out_valid   consumer side handshake (rd_data is 0 while not valid)
//   level                       stored word count, 0..DEPTH
//   almost_full, almost_empty   threshold flags on level
//   overflow, underflow, err_clr     sticky error flags and their clear
module hs_fifo_prog
    import hs_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - THRESH_OFFSET,
    parameter int AE_LEVEL = THRESH_OFFSET,
    localparam int LW      = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             data_in_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             data_out_valid,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int AW = LW - 1;

    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_rdata;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign data_in_ready  = !full;
    assign data_out_valid = !empty;

    assign push = wr_en && !full  && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    hs_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign rd_data = empty ? '0 : mem_rdata;

`ifdef HS_FIFO_STATUS_EN
    localparam logic [LW-1:0] AF_THR = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_THR = LW'(AE_LEVEL);

    logic [LW-1:0] level_int;
    logic          ovf_q;
    logic          unf_q;

    // Pointer difference is taken modulo 2^LW, so it stays correct across wrap.
    assign level_int    = wr_ptr - rd_ptr;
    assign level        = level_int;
    assign almost_full  = (level_int >= AF_THR);
    assign almost_empty = (level_int <= AE_THR);

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (wr_en && full)  || (ovf_q && !err_clr);
            unf_q <= (rd_en && empty) || (unf_q && !err_clr);
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign level          = '0;
    assign almost_full    = 1'b0;
    assign almost_empty   = 1'b0;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/hs_fifo_prog.md
# hs_fifo_prog

Parametrised successor to the team's handshake FIFO. It is a synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides, plus:
- configurable width and depth,
- a synchronous flush,
- a fill level output,
- programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags.

It sits between a producer and a consumer in the same clock domain. Typical use is as the elastic buffer in front of AXI-style stream sinks.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 32, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-4, almost_full asserts when level ≥ AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when level ≤ AE_LEVEL

Ports (LW = $clog2(DEPTH)+1):
- clk, in, 1, the single clock; all logic is rising-edge
- rst_n, in, 1, reset; asynchronous, active-low
- flush, in, 1, synchronous empty request
- wr_en, in, 1, producer valid
- wr_data, in, WIDTH, producer data
- data_in_ready, out, 1, FIFO can accept a word
- rd_en, in, 1, consumer ready
- rd_data, out, WIDTH, head word
- data_out_valid, out, 1, head word valid
- level, out, LW, number of stored words, 0..DEPTH
- almost_full, out, 1, threshold flag
- almost_empty, out, 1, threshold flag
- overflow, out, 1, sticky flag: write attempted while not ready
- underflow, out, 1, sticky flag: read attempted while not valid
- err_clr, in, 1, clears overflow and underflow

## Operation
Handshakes:
- Push occurs at an edge where wr_en && data_in_ready.
- Pop occurs at an edge where rd_en && data_out_valid.
- Storage is a DEPTH-entry array with write and read pointers of LW bits. The MSB is the wrap bit. full = pointers equal except the MSB; empty = pointers equal.

Output flags:
- data_in_ready = !full. data_out_valid = !empty. Both are derived from registered state; there is no combinational path from wr_en or rd_en to either.
- rd_data = mem[rd_ptr] when data_out_valid is high; forced to 0 when it is low.

Boundary cases:
- Push and pop in the same cycle, neither full nor empty: both happen, level unchanged.
- Full: data_in_ready is low, so a same-cycle pop does not admit a write in that cycle. There is no pass-through.
- Empty: a push is not readable in the same cycle. There is no bypass.
- Pointers wrap modulo 2·DEPTH; the array index is the low LW-1 bits.

Flush:
- On the next edge, both pointers go to 0 and level goes to 0.
- Flush wins over any same-cycle push or pop; those are dropped.
- Flush does not clear overflow or underflow.

Level and thresholds:
- level = wr_ptr − rd_ptr, computed modulo 2^LW.
- almost_full and almost_empty are compared against level as updated after the same edge.

Error flags:
- overflow sets on an edge where wr_en && !data_in_ready.
- underflow sets on an edge where rd_en && !data_out_valid.
- err_clr clears both flags. If a new error occurs in the same cycle as err_clr, the set wins.

## Timing
- Reset state:
  - pointers 0, level 0
  - data_in_ready 1, data_out_valid 0, rd_data 0
  - almost_full 0, almost_empty 1
  - overflow 0, underflow 0
- Write-to-read latency is 1 cycle: a push at edge k gives data_out_valid=1 and that word on rd_data in the cycle after edge k.
- Pop: the next word, or data_out_valid=0, appears in the cycle after the pop edge.
- Flags and level update on the same edge as the push, pop or flush that changes them.
- Reset asserted mid-operation: immediately returns every output to its reset state; stored data is discarded.

## Configuration
- HS_FIFO_STATUS_EN defined: level, almost_full, almost_empty, overflow and underflow behave as specified above.
- HS_FIFO_STATUS_EN not defined:
  - level, almost_full, almost_empty, overflow and underflow are tied to 0.
  - err_clr is ignored.
  - The threshold comparators and sticky registers are not built.
  - Data path and handshake behaviour are identical.

## Structure
- Package hs_fifo_pkg holds:
  - the clog2 helper function
  - the LW/pointer-width localparam derivation
  - the default threshold offsets (4)
- One sub-module, hs_fifo_ram: DEPTH×WIDTH simple dual-port array, one synchronous write port and one asynchronous read port. No reset on the array.
- Pointer, flag and flush logic live in hs_fifo_prog.

## Test plan
- Reset, then idle: data_in_ready=1, data_out_valid=0, rd_data=0, level=0, almost_empty=1 throughout.
- Push 1..32 with rd_en=0: level steps 1..32; almost_full rises at level 28; data_in_ready falls after the 32nd push. A 33rd wr_en sets overflow=1 and level stays 32.
- From full, hold rd_en=1 with wr_en=0: rd_data reads 1..32 in order, one per cycle. data_out_valid drops after word 32. A further rd_en sets underflow=1.
- Continuous push and pop at level 10 for 100 cycles: level stays 10 and output order matches input order. Run with random rd_en (seed 8721) and check the output against a scoreboard.
- Level 20, flush asserted together with wr_en and rd_en: next cycle level=0, data_out_valid=0, and no word was consumed. Sticky flags are retained until err_clr=1 clears them.
- Build without HS_FIFO_STATUS_EN and repeat the overflow case: overflow stays 0 and the data path results are unchanged.
